// File: rtl/demux_1_to_3_pkg.sv
// demux_1_to_3_pkg: datapath word width and channel select codes shared with the 3-to-1 mux
package demux_1_to_3_pkg;
  localparam int WORD_W = 16;
  localparam logic [1:0] SEL_CH0 = 2'b00;
  localparam logic [1:0] SEL_CH1 = 2'b01;
  localparam logic [1:0] SEL_CH2 = 2'b10;
  localparam logic [1:0] SEL_BAD = 2'b11;
endpackage

// File: rtl/demux_1_to_3_out_slot.sv
// out_slot: one-entry holding register with load, drain and valid tracking
module out_slot
  import demux_1_to_3_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic             o_free,
  output logic [WIDTH-1:0] o_data
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
  // a drain in the same cycle frees the slot for a new word
  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/demux_1_to_3.sv
// demux_1_to_3: registered 1-to-3 demultiplexer with per-channel holding slots and drop counter
module demux_1_to_3
  import demux_1_to_3_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [1:0]           select,
  input  logic                 valid_in,
  output logic                 ready_in,
  output logic [WIDTH-1:0]     data_out0,
  output logic [WIDTH-1:0]     data_out1,
  output logic [WIDTH-1:0]     data_out2,
  output logic                 valid_out0,
  output logic                 valid_out1,
  output logic                 valid_out2,
  input  logic                 ready_out0,
  input  logic                 ready_out1,
  input  logic                 ready_out2,
  output logic [ERR_CNT_W-1:0] drop_count,
  output logic                 error
);
  logic [2:0]           w_load;
  logic [2:0]           w_free;
  logic [2:0]           w_valid;
  logic [2:0]           w_ready;
  logic [WIDTH-1:0]     w_data [3];
  logic                 w_drop;
  logic [ERR_CNT_W-1:0] r_drop_count;
  logic                 r_error;
  assign w_ready = {ready_out2, ready_out1, ready_out0};
  genvar i;
  generate
    for (i = 0; i < 3; i++) begin : g_slot
      assign w_load[i] = valid_in && (select == 2'(i)) && w_free[i];
      out_slot #(.WIDTH(WIDTH)) u_slot (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_load[i]),
        .i_ready (w_ready[i]),
        .i_data  (data_in),
        .o_valid (w_valid[i]),
        .o_free  (w_free[i]),
        .o_data  (w_data[i])
      );
    end
  endgenerate
  always_comb begin
    ready_in = (select == SEL_CH0) ? w_free[0] :
               (select == SEL_CH1) ? w_free[1] :
               (select == SEL_CH2) ? w_free[2] : 1'b1;
  end
  assign w_drop = valid_in && (select == SEL_BAD);
  always_ff @(posedge clock) begin
    if (reset) begin
      r_drop_count <= '0;
      r_error      <= 1'b0;
    end else if (w_drop) begin
      r_drop_count <= (r_drop_count == '1) ? r_drop_count : r_drop_count + 1'b1;
      r_error      <= 1'b1;
    end
  end
  assign data_out0  = w_data[0];
  assign data_out1  = w_data[1];
  assign data_out2  = w_data[2];
  assign valid_out0 = w_valid[0];
  assign valid_out1 = w_valid[1];
  assign valid_out2 = w_valid[2];
  assign drop_count = r_drop_count;
  assign error      = r_error;
endmodule

// File: tb/tb_demux_1_to_3.sv
// tb_demux_1_to_3: directed vector table plus illegal-select and mid-run reset sequences
module tb_demux_1_to_3;
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [1:0]  select;
  logic        valid_in;
  logic        ready_in;
  logic [15:0] data_out0, data_out1, data_out2;
  logic        valid_out0, valid_out1, valid_out2;
  logic        ready_out0, ready_out1, ready_out2;
  logic [7:0]  drop_count;
  logic        error;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  demux_1_to_3 dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .select     (select),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .data_out2  (data_out2),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .valid_out2 (valid_out2),
    .ready_out0 (ready_out0),
    .ready_out1 (ready_out1),
    .ready_out2 (ready_out2),
    .drop_count (drop_count),
    .error      (error)
  );
  typedef struct {
    logic        rst;
    logic        vin;
    logic [1:0]  sel;
    logic [15:0] din;
    logic [2:0]  rdy;
    logic        e_rin;
    logic [2:0]  e_v;
    logic [15:0] e_d0;
    logic [15:0] e_d1;
    logic [15:0] e_d2;
    logic [7:0]  e_cnt;
    logic        e_err;
  } vec_t;
  vec_t tbl_a[$];
  vec_t tbl_b[$];
  function automatic vec_t mk(logic rst, logic vin, logic [1:0] sel, logic [15:0] din,
                              logic [2:0] rdy, logic e_rin, logic [2:0] e_v,
                              logic [15:0] e_d0, logic [15:0] e_d1, logic [15:0] e_d2,
                              logic [7:0] e_cnt, logic e_err);
    vec_t v;
    v.rst = rst; v.vin = vin; v.sel = sel; v.din = din; v.rdy = rdy; v.e_rin = e_rin;
    v.e_v = e_v; v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask
  task automatic drive(input logic rst, input logic vin, input logic [1:0] sel,
                       input logic [15:0] din, input logic [2:0] rdy);
    @(negedge clock);
    reset = rst; valid_in = vin; select = sel; data_in = din;
    {ready_out2, ready_out1, ready_out0} = rdy;
    #1;
  endtask
  task automatic apply(input vec_t v, input int idx);
    drive(v.rst, v.vin, v.sel, v.din, v.rdy);
    chk("ready_in", idx, 32'(ready_in), 32'(v.e_rin));
    @(posedge clock);
    #1;
    chk("valid_out", idx, 32'({valid_out2, valid_out1, valid_out0}), 32'(v.e_v));
    chk("data_out0", idx, 32'(data_out0), 32'(v.e_d0));
    chk("data_out1", idx, 32'(data_out1), 32'(v.e_d1));
    chk("data_out2", idx, 32'(data_out2), 32'(v.e_d2));
    chk("drop_count", idx, 32'(drop_count), 32'(v.e_cnt));
    chk("error", idx, 32'(error), 32'(v.e_err));
  endtask
  initial begin
    reset = 1'b1; valid_in = 1'b0; select = 2'b00; data_in = '0;
    {ready_out2, ready_out1, ready_out0} = 3'b111;
    //              rst vin sel    din       rdy     rin v       d0        d1        d2        cnt  err
    tbl_a.push_back(mk(1, 1, 2'd0, 16'hDEAD, 3'b111, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'd0, 0));
    tbl_a.push_back(mk(1, 1, 2'd0, 16'hDEAD, 3'b111, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'd0, 0));
    tbl_a.push_back(mk(0, 1, 2'd0, 16'h1234, 3'b111, 1, 3'b001, 16'h1234, 16'h0000, 16'h0000, 8'd0, 0));
    tbl_a.push_back(mk(0, 1, 2'd1, 16'hABCD, 3'b111, 1, 3'b010, 16'h1234, 16'hABCD, 16'h0000, 8'd0, 0));
    tbl_a.push_back(mk(0, 1, 2'd2, 16'h0F0F, 3'b111, 1, 3'b100, 16'h1234, 16'hABCD, 16'h0F0F, 8'd0, 0));
    tbl_a.push_back(mk(0, 0, 2'd0, 16'hFFFF, 3'b111, 1, 3'b000, 16'h1234, 16'hABCD, 16'h0F0F, 8'd0, 0));
    tbl_a.push_back(mk(0, 1, 2'd1, 16'h1111, 3'b101, 1, 3'b010, 16'h1234, 16'h1111, 16'h0F0F, 8'd0, 0));
    tbl_a.push_back(mk(0, 1, 2'd1, 16'h2222, 3'b101, 0, 3'b010, 16'h1234, 16'h1111, 16'h0F0F, 8'd0, 0));
    tbl_a.push_back(mk(0, 1, 2'd1, 16'h2222, 3'b101, 0, 3'b010, 16'h1234, 16'h1111, 16'h0F0F, 8'd0, 0));
    tbl_a.push_back(mk(0, 1, 2'd2, 16'h5555, 3'b101, 1, 3'b110, 16'h1234, 16'h1111, 16'h5555, 8'd0, 0));
    tbl_a.push_back(mk(0, 1, 2'd1, 16'h2222, 3'b111, 1, 3'b010, 16'h1234, 16'h2222, 16'h5555, 8'd0, 0));
    tbl_a.push_back(mk(0, 0, 2'd1, 16'h3333, 3'b111, 1, 3'b000, 16'h1234, 16'h2222, 16'h5555, 8'd0, 0));
    tbl_a.push_back(mk(0, 1, 2'd0, 16'h4242, 3'b110, 1, 3'b001, 16'h4242, 16'h2222, 16'h5555, 8'd0, 0));
    tbl_b.push_back(mk(0, 1, 2'd1, 16'h6666, 3'b000, 1, 3'b011, 16'h4242, 16'h6666, 16'h5555, 8'd255, 1));
    tbl_b.push_back(mk(0, 1, 2'd2, 16'h8888, 3'b000, 1, 3'b111, 16'h4242, 16'h6666, 16'h8888, 8'd255, 1));
    tbl_b.push_back(mk(0, 1, 2'd0, 16'h9999, 3'b000, 0, 3'b111, 16'h4242, 16'h6666, 16'h8888, 8'd255, 1));
    tbl_b.push_back(mk(1, 1, 2'd0, 16'h9999, 3'b000, 0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 8'd0, 0));
    tbl_b.push_back(mk(0, 1, 2'd0, 16'h7777, 3'b000, 1, 3'b001, 16'h7777, 16'h0000, 16'h0000, 8'd0, 0));
    tbl_b.push_back(mk(0, 0, 2'd0, 16'h0000, 3'b111, 1, 3'b000, 16'h7777, 16'h0000, 16'h0000, 8'd0, 0));
    foreach (tbl_a[k]) apply(tbl_a[k], k);
    // 300 illegal-select words with channel 0 stalled and full
    for (int n = 0; n < 300; n++) begin
      drive(1'b0, 1'b1, 2'b11, 16'(n), 3'b110);
      chk("bad_ready_in", 100 + n, 32'(ready_in), 32'd1);
      @(posedge clock);
      #1;
      chk("bad_valid_out", 100 + n, 32'({valid_out2, valid_out1, valid_out0}), 32'b001);
      chk("bad_data_out0", 100 + n, 32'(data_out0), 32'h4242);
      chk("bad_drop_count", 100 + n, 32'(drop_count), (n + 1 > 255) ? 32'd255 : 32'(n + 1));
      chk("bad_error", 100 + n, 32'(error), 32'd1);
    end
    foreach (tbl_b[k]) apply(tbl_b[k], 500 + k);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
